// File: rtl/ifu_line_fetch.sv
// ifu_line_fetch -- instruction-cache line refill engine.
//
// Sits behind the IFU I$ miss port. On a miss request it latches the tag,
// issues one word read per line word to instruction memory, collects the
// in-order read responses into a line buffer, and presents line + tag to the
// cache for exactly one cycle.
//
// Ports:
//   Clock, Rst                 clock, async active-high reset
//   mem_reqTag*In              miss request from the cache (tag + valid)
//   mem_rsp*Out                delivered line/tag, valid pulses one cycle
//   imem_req*                  word read request (valid/ready handshake)
//   imem_rsp*In                in-order read data return
//   busyOut, debug_state       refill-in-progress flag, encoded FSM state

// One word slot of the line buffer. Each slot only accepts the write whose
// receive index selects it.
module ifu_lf_word_slot #(
  parameter int WORD_WIDTH = 32,
  parameter int WIDX_W     = 2,
  parameter int IDX        = 0
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic                  wr_en,
  input  logic [WIDX_W-1:0]     wr_idx,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic [WORD_WIDTH-1:0] word
);
  localparam logic [WIDX_W-1:0] MY_IDX = WIDX_W'(IDX);

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst)                           word <= '0;
    else if (wr_en && wr_idx == MY_IDX) word <= wr_data;
  end
endmodule

module ifu_line_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 28,
  parameter int LINE_WIDTH = 128,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic [TAG_WIDTH-1:0]  mem_reqTagIn,
  input  logic                  mem_reqTagValidIn,
  output logic [TAG_WIDTH-1:0]  mem_rspTagOut,
  output logic [LINE_WIDTH-1:0] mem_rspInsLineOut,
  output logic                  mem_rspInsLineValidOut,
  output logic                  imem_reqValidOut,
  output logic [ADDR_WIDTH-1:0] imem_reqAddrOut,
  input  logic                  imem_reqReadyIn,
  input  logic                  imem_rspValidIn,
  input  logic [WORD_WIDTH-1:0] imem_rspDataIn,
  output logic                  busyOut,
  output logic [1:0]            debug_state
);
  localparam int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH;
  localparam int WIDX_W         = $clog2(WORDS_PER_LINE);
  localparam int BYTE_W         = $clog2(WORD_WIDTH / 8);
  // One extra bit so "all words received" is representable without wrap.
  localparam int CNT_W          = WIDX_W + 1;

  localparam logic [CNT_W-1:0] WPL_C  = CNT_W'(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  if (TAG_WIDTH + WIDX_W + BYTE_W != ADDR_WIDTH) begin : g_bad_geometry
    $error("ifu_line_fetch: TAG_WIDTH + WIDX_W + BYTE_W must equal ADDR_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        issue_cnt, issue_cnt_nxt;
  logic [CNT_W-1:0]        rcv_cnt, rcv_cnt_nxt;
  logic [TAG_WIDTH-1:0]    tag_q, tag_nxt;
  logic [TAG_WIDTH-1:0]    hold_tag;
  logic [LINE_WIDTH-1:0]   hold_line;
  logic                    rsp_take;

  logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] line_words;
  logic [LINE_WIDTH-1:0]   line_buf;

  // Line buffer: word i lands at bits [i*WORD_WIDTH +: WORD_WIDTH].
  for (genvar i = 0; i < WORDS_PER_LINE; i++) begin : g_slot
    ifu_lf_word_slot #(
      .WORD_WIDTH (WORD_WIDTH),
      .WIDX_W     (WIDX_W),
      .IDX        (i)
    ) u_slot (
      .Clock   (Clock),
      .Rst     (Rst),
      .wr_en   (rsp_take),
      .wr_idx  (rcv_cnt[WIDX_W-1:0]),
      .wr_data (imem_rspDataIn),
      .word    (line_words[i])
    );
  end
  assign line_buf = line_words;

  // Next-state / outputs.
  always_comb begin
    state_nxt        = state;
    issue_cnt_nxt    = issue_cnt;
    rcv_cnt_nxt      = rcv_cnt;
    tag_nxt          = tag_q;
    imem_reqValidOut = 1'b0;
    imem_reqAddrOut  = '0;
    mem_rspInsLineValidOut = 1'b0;

    // Responses count in FETCH and DRAIN only; anything past a full line,
    // or arriving while idle, is dropped.
    rsp_take = ((state == S_FETCH) || (state == S_DRAIN)) &&
               imem_rspValidIn && (rcv_cnt < WPL_C);
    if (rsp_take) rcv_cnt_nxt = rcv_cnt + ONE_C;

    case (state)
      S_IDLE: begin
        if (mem_reqTagValidIn) begin
          tag_nxt       = mem_reqTagIn;
          issue_cnt_nxt = '0;
          rcv_cnt_nxt   = '0;
          state_nxt     = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_reqValidOut = 1'b1;
        imem_reqAddrOut  = {tag_q, issue_cnt[WIDX_W-1:0], {BYTE_W{1'b0}}};
        if (imem_reqReadyIn) begin
          issue_cnt_nxt = issue_cnt + ONE_C;
          // Last word accepted: skip DRAIN if its data came back the same cycle.
          if (issue_cnt == LAST_C)
            state_nxt = (rcv_cnt_nxt == WPL_C) ? S_RESP : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rcv_cnt_nxt == WPL_C) state_nxt = S_RESP;
      end
      S_RESP: begin
        mem_rspInsLineValidOut = 1'b1;
        state_nxt              = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outside RESP the data/tag outputs show the last delivered line, so the
  // buffer being overwritten by a new refill never leaks to the cache.
  assign mem_rspTagOut     = (state == S_RESP) ? tag_q    : hold_tag;
  assign mem_rspInsLineOut = (state == S_RESP) ? line_buf : hold_line;
  assign busyOut           = (state != S_IDLE);
  assign debug_state       = state;

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state     <= S_IDLE;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
      tag_q     <= '0;
      hold_tag  <= '0;
      hold_line <= '0;
    end else begin
      state     <= state_nxt;
      issue_cnt <= issue_cnt_nxt;
      rcv_cnt   <= rcv_cnt_nxt;
      tag_q     <= tag_nxt;
      if (state == S_RESP) begin
        hold_tag  <= tag_q;
        hold_line <= line_buf;
      end
    end
  end
endmodule

// File: tb/tb_ifu_line_fetch.sv
module tb_ifu_line_fetch;
  logic          Clock, Rst;
  logic [27:0]   mem_reqTagIn;
  logic          mem_reqTagValidIn;
  logic [27:0]   mem_rspTagOut;
  logic [127:0]  mem_rspInsLineOut;
  logic          mem_rspInsLineValidOut;
  logic          imem_reqValidOut;
  logic [31:0]   imem_reqAddrOut;
  logic          imem_reqReadyIn;
  logic          imem_rspValidIn;
  logic [31:0]   imem_rspDataIn;
  logic          busyOut;
  logic [1:0]    debug_state;

  ifu_line_fetch dut (
    .Clock(Clock), .Rst(Rst),
    .mem_reqTagIn(mem_reqTagIn), .mem_reqTagValidIn(mem_reqTagValidIn),
    .mem_rspTagOut(mem_rspTagOut), .mem_rspInsLineOut(mem_rspInsLineOut),
    .mem_rspInsLineValidOut(mem_rspInsLineValidOut),
    .imem_reqValidOut(imem_reqValidOut), .imem_reqAddrOut(imem_reqAddrOut),
    .imem_reqReadyIn(imem_reqReadyIn), .imem_rspValidIn(imem_rspValidIn),
    .imem_rspDataIn(imem_rspDataIn), .busyOut(busyOut), .debug_state(debug_state)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct { logic [31:0] data; int due; } rsp_t;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  // memory model / observation state
  rsp_t         pend[$];
  logic [31:0]  iss_addr[$];
  int           delay_tab[4];
  bit           use_tab = 1;
  int           ready_pct = 100;
  int           stall_word = 0, stall_rem = 0;
  logic [31:0]  dseed = '0;
  int           word_vis[4];
  int           rsp_driven = 0;
  bit           rand_req = 0;
  bit           track_busy = 0;
  int           busy_gap = 0;
  int           resp_cnt = 0, resp_cyc = 0, hold_viol = 0;
  logic [127:0] last_line = '0;
  logic [27:0]  last_tag = '0;

  // Reference: word i of a line for tag t lives at {t, i, 2'b00}; memory
  // returns address XOR seed; line is words packed with word 0 at the LSB.
  function automatic logic [31:0] exp_addr(logic [27:0] t, int i);
    logic [1:0] w = i[1:0];
    return {t, w, 2'b00};
  endfunction
  function automatic logic [127:0] exp_line(logic [27:0] t, logic [31:0] s);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = exp_addr(t, i) ^ s;
    return l;
  endfunction

  // One clock of the memory model, called at posedge+1.
  task automatic cycle();
    bit rdy;
    rsp_t p;
    int ex;
    if (mem_rspInsLineValidOut) begin
      resp_cnt++; resp_cyc = cyc;
      last_line = mem_rspInsLineOut; last_tag = mem_rspTagOut;
    end else if (mem_rspInsLineOut !== last_line || mem_rspTagOut !== last_tag) begin
      hold_viol++;
    end
    if (track_busy && busyOut !== 1'b1) busy_gap++;
    if (imem_reqValidOut) word_vis[imem_reqAddrOut[3:2]]++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rspValidIn = 1'b1; imem_rspDataIn = pend[0].data;
      void'(pend.pop_front()); rsp_driven++;
    end else begin
      imem_rspValidIn = 1'b0; imem_rspDataIn = $urandom;
    end
    rdy = 1'b1;
    if (imem_reqValidOut && stall_rem > 0 && imem_reqAddrOut[3:2] == stall_word[1:0]) begin
      rdy = 1'b0; stall_rem--;
    end else if (int'($urandom_range(99)) >= ready_pct) rdy = 1'b0;
    imem_reqReadyIn = rdy;
    if (imem_reqValidOut && rdy) begin
      iss_addr.push_back(imem_reqAddrOut);
      ex = use_tab ? delay_tab[imem_reqAddrOut[3:2]] : int'($urandom_range(3));
      p.data = imem_reqAddrOut ^ dseed;
      p.due  = cyc + 1 + ex;
      if (pend.size() > 0 && p.due < pend[$].due) p.due = pend[$].due;
      pend.push_back(p);
    end
    @(posedge Clock); #1; cyc++;
  endtask

  task automatic wait_resp(input int budget, output bit ok);
    int r0 = resp_cnt;
    int n = 0;
    while (resp_cnt == r0 && n < budget) begin
      if (rand_req) begin
        mem_reqTagIn = 28'($urandom); mem_reqTagValidIn = 1'($urandom);
      end
      cycle(); n++;
    end
    ok = (resp_cnt != r0);
  endtask

  task automatic clear_obs();
    iss_addr.delete();
    for (int i = 0; i < 4; i++) word_vis[i] = 0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; mem_reqTagIn = '0; mem_reqTagValidIn = 1'b0;
    imem_reqReadyIn = 1'b0; imem_rspValidIn = 1'b0; imem_rspDataIn = '0;
    for (int i = 0; i < 4; i++) delay_tab[i] = 0;
    repeat (2) @(posedge Clock); #1;
    n_chk++; if (mem_rspInsLineValidOut !== 1'b0) $display("FAIL reset_rspvalid: got %b want 0", mem_rspInsLineValidOut); else n_pass++;
    n_chk++; if (imem_reqValidOut !== 1'b0) $display("FAIL reset_reqvalid: got %b want 0", imem_reqValidOut); else n_pass++;
    n_chk++; if (imem_reqAddrOut !== 32'h0) $display("FAIL reset_addr: got %h want 0", imem_reqAddrOut); else n_pass++;
    n_chk++; if (busyOut !== 1'b0) $display("FAIL reset_busy: got %b want 0", busyOut); else n_pass++;
    n_chk++; if (debug_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", debug_state); else n_pass++;
    n_chk++; if (mem_rspInsLineOut !== 128'h0) $display("FAIL reset_line: got %h want 0", mem_rspInsLineOut); else n_pass++;
    n_chk++; if (mem_rspTagOut !== 28'h0) $display("FAIL reset_tag: got %h want 0", mem_rspTagOut); else n_pass++;
    Rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok; int c0, r0;
    clear_obs(); dseed = '0; ready_pct = 100; use_tab = 1;
    c0 = cyc; r0 = resp_cnt;
    mem_reqTagIn = 28'h0000010; mem_reqTagValidIn = 1'b1;
    cycle(); mem_reqTagValidIn = 1'b0;
    wait_resp(50, ok);
    n_chk++; if (!ok) $display("FAIL basic_timeout: got no RESP want RESP within 50 cycles"); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (iss_addr.size() <= i || iss_addr[i] !== 32'h100 + 32'(4*i))
        $display("FAIL basic_addr%0d: got %h want %h", i, (iss_addr.size() > i) ? iss_addr[i] : 32'hx, 32'h100 + 32'(4*i));
      else n_pass++;
    end
    n_chk++; if (last_line !== 128'h0000010C_00000108_00000104_00000100) $display("FAIL basic_line: got %h want 0000010c000001080000010400000100", last_line); else n_pass++;
    n_chk++; if (last_tag !== 28'h0000010) $display("FAIL basic_tag: got %h want 0000010", last_tag); else n_pass++;
    n_chk++; if (resp_cyc - c0 != 6) $display("FAIL basic_latency: got %0d want 6", resp_cyc - c0); else n_pass++;
    repeat (3) cycle();
    n_chk++; if (resp_cnt != r0 + 1) $display("FAIL basic_pulses: got %0d want 1", resp_cnt - r0); else n_pass++;
    n_chk++; if (busyOut !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", busyOut); else n_pass++;
    n_chk++; if (hold_viol != 0) $display("FAIL basic_hold: got %0d changes want 0", hold_viol); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok; int c0;
    clear_obs(); dseed = '0; stall_word = 2; stall_rem = 3;
    c0 = cyc;
    mem_reqTagIn = 28'h0000010; mem_reqTagValidIn = 1'b1;
    cycle(); mem_reqTagValidIn = 1'b0;
    wait_resp(50, ok);
    n_chk++; if (!ok) $display("FAIL bp_timeout: got no RESP want RESP within 50 cycles"); else n_pass++;
    n_chk++; if (word_vis[2] != 4) $display("FAIL bp_addr_hold: got %0d cycles at 0x108 want 4", word_vis[2]); else n_pass++;
    n_chk++; if (last_line !== 128'h0000010C_00000108_00000104_00000100) $display("FAIL bp_line: got %h want 0000010c000001080000010400000100", last_line); else n_pass++;
    n_chk++; if (resp_cyc - c0 != 9) $display("FAIL bp_latency: got %0d want 9", resp_cyc - c0); else n_pass++;
    repeat (2) cycle();
  endtask

  task automatic test_tag_change();
    bit ok; int r1;
    clear_obs(); dseed = '0;
    mem_reqTagIn = 28'h0000010; mem_reqTagValidIn = 1'b1;
    cycle(); cycle();
    mem_reqTagIn = 28'h0000020;
    wait_resp(50, ok);
    n_chk++; if (!ok) $display("FAIL tc_timeout1: got no RESP want RESP"); else n_pass++;
    n_chk++; if (last_tag !== 28'h10) $display("FAIL tc_tag1: got %h want 0000010", last_tag); else n_pass++;
    n_chk++; if (last_line !== exp_line(28'h10, '0)) $display("FAIL tc_line1: got %h want %h", last_line, exp_line(28'h10, '0)); else n_pass++;
    r1 = resp_cyc;
    cycle(); mem_reqTagValidIn = 1'b0;
    wait_resp(50, ok);
    n_chk++; if (!ok) $display("FAIL tc_timeout2: got no RESP want RESP"); else n_pass++;
    n_chk++; if (last_tag !== 28'h20) $display("FAIL tc_tag2: got %h want 0000020", last_tag); else n_pass++;
    n_chk++; if (iss_addr.size() < 5 || iss_addr[4] !== 32'h200) $display("FAIL tc_addr2: got %h want 00000200", (iss_addr.size() > 4) ? iss_addr[4] : 32'hx); else n_pass++;
    n_chk++; if (resp_cyc - r1 != 7) $display("FAIL tc_spacing: got %0d want 7", resp_cyc - r1); else n_pass++;
    repeat (2) cycle();
  endtask

  task automatic test_var_latency();
    bit ok; int r0;
    clear_obs(); dseed = 32'h5A5A_0F0F;
    delay_tab[0] = 0; delay_tab[1] = 3; delay_tab[2] = 1; delay_tab[3] = 5;
    r0 = resp_cnt; busy_gap = 0;
    mem_reqTagIn = 28'hABCDE12; mem_reqTagValidIn = 1'b1;
    cycle(); mem_reqTagValidIn = 1'b0; track_busy = 1;
    wait_resp(60, ok);
    track_busy = 0;
    n_chk++; if (!ok) $display("FAIL vl_timeout: got no RESP want RESP"); else n_pass++;
    n_chk++; if (last_line !== exp_line(28'hABCDE12, dseed)) $display("FAIL vl_line: got %h want %h", last_line, exp_line(28'hABCDE12, dseed)); else n_pass++;
    n_chk++; if (busy_gap != 0) $display("FAIL vl_busy: got %0d idle cycles want 0", busy_gap); else n_pass++;
    repeat (3) cycle();
    n_chk++; if (resp_cnt != r0 + 1) $display("FAIL vl_pulses: got %0d want 1", resp_cnt - r0); else n_pass++;
    n_chk++; if (busyOut !== 1'b0) $display("FAIL vl_idle_busy: got %b want 0", busyOut); else n_pass++;
    for (int i = 0; i < 4; i++) delay_tab[i] = 0;
  endtask

  task automatic test_reset_mid();
    bit ok; int r0, d0, n;
    clear_obs(); dseed = 32'h1234_5678;
    for (int i = 0; i < 4; i++) delay_tab[i] = 3;
    r0 = resp_cnt; d0 = rsp_driven; n = 0;
    mem_reqTagIn = 28'h0000777; mem_reqTagValidIn = 1'b1;
    cycle(); mem_reqTagValidIn = 1'b0;
    while (rsp_driven < d0 + 2 && n < 40) begin cycle(); n++; end
    n_chk++; if (rsp_driven < d0 + 2) $display("FAIL rm_setup: got %0d responses want 2", rsp_driven - d0); else n_pass++;
    Rst = 1'b1; #1;
    n_chk++; if (busyOut !== 1'b0) $display("FAIL rm_busy: got %b want 0", busyOut); else n_pass++;
    n_chk++; if (debug_state !== 2'd0) $display("FAIL rm_state: got %0d want 0", debug_state); else n_pass++;
    n_chk++; if (imem_reqValidOut !== 1'b0 || imem_reqAddrOut !== 32'h0) $display("FAIL rm_req: got v=%b a=%h want 0/0", imem_reqValidOut, imem_reqAddrOut); else n_pass++;
    n_chk++; if (mem_rspInsLineOut !== 128'h0 || mem_rspTagOut !== 28'h0) $display("FAIL rm_outs: got line=%h tag=%h want 0", mem_rspInsLineOut, mem_rspTagOut); else n_pass++;
    Rst = 1'b0;
    last_line = '0; last_tag = '0; hold_viol = 0;
    for (int i = 0; i < 4; i++) delay_tab[i] = 0;
    n = 0;
    while (pend.size() > 0 && n < 20) begin cycle(); n++; end
    repeat (3) cycle();
    n_chk++; if (resp_cnt != r0) $display("FAIL rm_no_resp: got %0d pulses want 0", resp_cnt - r0); else n_pass++;
    n_chk++; if (busyOut !== 1'b0) $display("FAIL rm_late_rsp_busy: got %b want 0", busyOut); else n_pass++;
    n_chk++; if (hold_viol != 0) $display("FAIL rm_hold: got %0d changes want 0", hold_viol); else n_pass++;
    dseed = 32'hCAFE_0001;
    mem_reqTagIn = 28'h0000888; mem_reqTagValidIn = 1'b1;
    cycle(); mem_reqTagValidIn = 1'b0;
    wait_resp(50, ok);
    n_chk++; if (!ok) $display("FAIL rm_refill_timeout: got no RESP want RESP"); else n_pass++;
    n_chk++; if (last_line !== exp_line(28'h888, dseed) || last_tag !== 28'h888) $display("FAIL rm_refill: got %h/%h want %h/0000888", last_line, last_tag, exp_line(28'h888, dseed)); else n_pass++;
    repeat (2) cycle();
  endtask

  task automatic test_back_to_back();
    bit ok; int r0, prev;
    logic [27:0] tags[3];
    for (int i = 0; i < 3; i++) tags[i] = 28'($urandom);
    dseed = 32'(($urandom));
    r0 = resp_cnt; prev = 0;
    mem_reqTagIn = tags[0]; mem_reqTagValidIn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_resp(50, ok);
      n_chk++; if (!ok || last_tag !== tags[k] || last_line !== exp_line(tags[k], dseed))
        $display("FAIL b2b_line%0d: got %h/%h want %h/%h", k, last_tag, last_line, tags[k], exp_line(tags[k], dseed));
      else n_pass++;
      if (k > 0) begin
        n_chk++; if (resp_cyc - prev != 7) $display("FAIL b2b_spacing%0d: got %0d want 7", k, resp_cyc - prev); else n_pass++;
      end
      prev = resp_cyc;
      if (k < 2) mem_reqTagIn = tags[k+1]; else mem_reqTagValidIn = 1'b0;
    end
    repeat (10) cycle();
    n_chk++; if (resp_cnt != r0 + 3) $display("FAIL b2b_pulses: got %0d want 3", resp_cnt - r0); else n_pass++;
  endtask

  task automatic test_random();
    bit ok, aok; int r0;
    logic [27:0] t;
    ready_pct = 60; use_tab = 0;
    for (int k = 0; k < 12; k++) begin
      clear_obs();
      t = 28'($urandom); dseed = 32'($urandom); r0 = resp_cnt;
      mem_reqTagIn = t; mem_reqTagValidIn = 1'b1;
      cycle();
      rand_req = 1;
      wait_resp(200, ok);
      rand_req = 0; mem_reqTagValidIn = 1'b0;
      n_chk++; if (!ok) $display("FAIL rand%0d_timeout: got no RESP want RESP", k); else n_pass++;
      n_chk++; if (last_tag !== t || last_line !== exp_line(t, dseed))
        $display("FAIL rand%0d_line: got %h/%h want %h/%h", k, last_tag, last_line, t, exp_line(t, dseed));
      else n_pass++;
      aok = (iss_addr.size() == 4);
      for (int i = 0; i < 4 && aok; i++) if (iss_addr[i] !== exp_addr(t, i)) aok = 0;
      n_chk++; if (!aok) $display("FAIL rand%0d_addrs: got %0d reads first %h want 4 from %h", k, iss_addr.size(), (iss_addr.size() > 0) ? iss_addr[0] : 32'hx, exp_addr(t, 0)); else n_pass++;
      repeat (2) cycle();
      n_chk++; if (resp_cnt != r0 + 1) $display("FAIL rand%0d_pulses: got %0d want 1", k, resp_cnt - r0); else n_pass++;
    end
    n_chk++; if (hold_viol != 0) $display("FAIL rand_hold: got %0d changes want 0", hold_viol); else n_pass++;
    ready_pct = 100; use_tab = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_tag_change();
    test_var_latency();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit want completion");
    $fatal(1, "watchdog");
  end
endmodule
